// File: rtl/nios_fprint_cpu_oci_dct_packer.sv
// nios_fprint_cpu_oci_dct_packer
// Packs 2-bit CPU trace atoms LSB-first into 30-bit DCT frames and hands
// them to the OCI trace sink over a valid/ready handshake. The accumulator
// and the output frame register are separate, so a new frame can be built
// while the previous one waits for the sink.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   atom_valid     trace atom offered this cycle
//   atom_data      trace atom value
//   atom_ready     packer takes the offered atom this cycle
//   flush          single-cycle request to emit the partial frame
//   test_ending    level; starts the end-of-test drain
//   dct_buffer     packed frame, atom k at bits [2k+1:2k]
//   dct_count      number of valid atoms in dct_buffer
//   dct_valid      frame presented to the sink
//   dct_ready      sink takes the frame this cycle
//   test_has_ended drain complete; sticky until reset
module nios_fprint_cpu_oci_dct_packer #(
  parameter int unsigned ATOM_W = 2,
  parameter int unsigned SLOTS  = 15,
  parameter int unsigned BUF_W  = 30,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom_data,
  output logic              atom_ready,
  input  logic              flush,
  input  logic              test_ending,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              dct_valid,
  input  logic              dct_ready,
  output logic              test_has_ended
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Accumulator side
  logic [BUF_W-1:0] acc;
  logic [CNT_W-1:0] acc_cnt;
  logic             flush_pending;
  logic             ending;

  // Next-state values
  logic [BUF_W-1:0] acc_n;
  logic [CNT_W-1:0] acc_cnt_n;
  logic             flush_pending_n;
  logic             ending_n;
  logic [BUF_W-1:0] dct_buffer_n;
  logic [CNT_W-1:0] dct_count_n;
  logic             dct_valid_n;
  logic             test_has_ended_n;

  // Decode helpers
  logic             accept;
  logic             out_free;
  logic             fill_move;
  logic             drain_req;
  logic             move;
  logic [BUF_W-1:0] acc_ins;

  // Ready depends on registered state only
  assign atom_ready = (acc_cnt < CNT_FULL) && !ending;
  assign accept     = atom_valid && atom_ready;
  assign out_free   = !dct_valid || dct_ready;

  // The atom completing a frame travels with it, giving one-cycle latency
  assign fill_move  = accept && (acc_cnt == CNT_LAST);
  assign drain_req  = (acc_cnt == CNT_FULL) ||
                      ((flush_pending || ending) && (acc_cnt != '0));
  assign move       = out_free && (fill_move || drain_req);

  // Accumulator with the offered atom written into slot acc_cnt
  always_comb begin
    acc_ins = acc;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (acc_cnt == CNT_W'(k)) begin
        acc_ins[k*ATOM_W +: ATOM_W] = atom_data;
      end
    end
  end

  // Next-state computation
  always_comb begin
    acc_n            = acc;
    acc_cnt_n        = acc_cnt;
    flush_pending_n  = flush_pending;
    ending_n         = ending | test_ending;
    dct_buffer_n     = dct_buffer;
    dct_count_n      = dct_count;
    dct_valid_n      = dct_valid && !dct_ready;
    test_has_ended_n = test_has_ended;

    if (move) begin
      dct_buffer_n    = fill_move ? acc_ins : acc;
      dct_count_n     = fill_move ? CNT_FULL : acc_cnt;
      dct_valid_n     = 1'b1;
      flush_pending_n = 1'b0;
      acc_n           = '0;
      acc_cnt_n       = '0;
      // An atom taken during a drain move starts the fresh accumulator
      if (accept && !fill_move) begin
        acc_n[ATOM_W-1:0] = atom_data;
        acc_cnt_n         = CNT_ONE;
      end
    end else if (accept) begin
      acc_n     = acc_ins;
      acc_cnt_n = acc_cnt + CNT_ONE;
    end

    if (flush) begin
      flush_pending_n = 1'b1;
    end
    // Nothing left to flush: drop the request so no empty frame is sent
    if (acc_cnt_n == '0) begin
      flush_pending_n = 1'b0;
    end

    if (ending && (acc_cnt_n == '0) && !dct_valid_n) begin
      test_has_ended_n = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc            <= '0;
      acc_cnt        <= '0;
      flush_pending  <= 1'b0;
      ending         <= 1'b0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      dct_valid      <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      acc            <= acc_n;
      acc_cnt        <= acc_cnt_n;
      flush_pending  <= flush_pending_n;
      ending         <= ending_n;
      dct_buffer     <= dct_buffer_n;
      dct_count      <= dct_count_n;
      dct_valid      <= dct_valid_n;
      test_has_ended <= test_has_ended_n;
    end
  end

endmodule

// File: tb/tb_nios_fprint_cpu_oci_dct_packer.sv
// Bench for nios_fprint_cpu_oci_dct_packer: directed scenarios, a queue-based
// model of the packer checked every cycle, and literal frame expectations.
module tb_nios_fprint_cpu_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom_data = 2'd0;
  logic        atom_ready;
  logic        flush = 1'b0;
  logic        test_ending = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready = 1'b0;
  logic        test_has_ended;

  always #5 clk = ~clk;

  nios_fprint_cpu_oci_dct_packer #(
    .ATOM_W(2), .SLOTS(15), .BUF_W(30), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .atom_valid(atom_valid), .atom_data(atom_data), .atom_ready(atom_ready),
    .flush(flush), .test_ending(test_ending),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
    .dct_ready(dct_ready), .test_has_ended(test_has_ended)
  );

  typedef struct {
    logic [29:0] b;
    int          c;
    int          cyc;
  } frame_t;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit armed  = 0;

  logic [1:0] src_q[$];   // atoms waiting to be offered
  logic [1:0] m_acc[$];   // model accumulator
  bit          m_valid, m_flush, m_ending, m_ended;
  logic [29:0] m_buf;
  int          m_cnt;
  frame_t      d_log[$];  // frames the DUT handed over
  frame_t      m_log[$];  // frames the model handed over

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic emit();
    m_buf = '0;
    for (int k = 0; k < m_acc.size(); k++) m_buf = m_buf | (30'(m_acc[k]) << (2 * k));
    m_cnt   = m_acc.size();
    m_valid = 1'b1;
    m_acc.delete();
    m_flush = 1'b0;
  endtask

  // Behavioural model, advanced on every rising edge
  always @(posedge clk) begin : model
    bit acc_ok, free, want;
    cycle++;
    armed = 1'b1;
    if (dct_valid && dct_ready) d_log.push_back('{b: dct_buffer, c: int'(dct_count), cyc: cycle});
    if (reset) begin
      m_acc.delete();
      m_valid = 0; m_flush = 0; m_ending = 0; m_ended = 0;
      m_buf = '0; m_cnt = 0;
    end else begin
      acc_ok = atom_valid && (m_acc.size() < 15) && !m_ending;
      free   = !m_valid || dct_ready;
      want   = (m_acc.size() == 15) || ((m_flush || m_ending) && m_acc.size() > 0);
      if (m_valid && dct_ready) begin
        m_log.push_back('{b: m_buf, c: m_cnt, cyc: cycle});
        m_valid = 1'b0;
      end
      if (acc_ok) void'(src_q.pop_front());
      if (acc_ok && m_acc.size() == 14 && free) begin
        m_acc.push_back(atom_data);
        emit();
      end else begin
        if (want && free) emit();
        if (acc_ok) m_acc.push_back(atom_data);
      end
      m_flush = m_flush || flush;
      if (m_acc.size() == 0) m_flush = 1'b0;
      if (m_ending && m_acc.size() == 0 && !m_valid) m_ended = 1'b1;
      if (test_ending) m_ending = 1'b1;
    end
  end

  // Atom source: offers the head of src_q shortly after each edge
  always @(posedge clk) begin
    #1;
    atom_valid = (src_q.size() > 0);
    atom_data  = (src_q.size() > 0) ? src_q[0] : 2'd0;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("atom_ready", 32'(atom_ready), 32'((m_acc.size() < 15) && !m_ending));
      chk("dct_valid", 32'(dct_valid), 32'(m_valid));
      chk("test_has_ended", 32'(test_has_ended), 32'(m_ended));
      if (m_valid) begin
        chk("dct_buffer", 32'(dct_buffer), 32'(m_buf));
        chk("dct_count", 32'(dct_count), 32'(m_cnt));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_src_empty(output int stalls);
    int n = 0;
    stalls = 0;
    while (src_q.size() != 0 && n < 200) begin
      @(negedge clk);
      if (src_q.size() != 0 && !atom_ready) stalls++;
      n++;
    end
    if (src_q.size() != 0) chk("timeout_atoms", 32'(src_q.size()), 32'd0);
  endtask

  task automatic wait_frames(input int want);
    int n = 0;
    while (d_log.size() < want && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (d_log.size() < want) chk("timeout_frames", 32'(d_log.size()), 32'(want));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [29:0] exp_buf[10];
  int          exp_cnt[10];

  initial begin
    int st;
    exp_buf[0] = 30'h24E4E4E4; exp_cnt[0] = 15;
    exp_buf[1] = 30'h0000001F; exp_cnt[1] = 3;
    exp_buf[2] = 30'h24E4E4E4; exp_cnt[2] = 15;
    exp_buf[3] = 30'h13939393; exp_cnt[3] = 15;
    exp_buf[4] = 30'h0000000E; exp_cnt[4] = 2;
    exp_buf[5] = 30'h15555555; exp_cnt[5] = 15;
    exp_buf[6] = 30'h00000002; exp_cnt[6] = 1;
    exp_buf[7] = 30'h00000039; exp_cnt[7] = 3;
    exp_buf[8] = 30'h00000020; exp_cnt[8] = 3;
    exp_buf[9] = 30'h0000031B; exp_cnt[9] = 5;

    // Reset state
    cycles(3);
    reset = 1'b0;
    chk("rst_dct_valid", 32'(dct_valid), 32'd0);
    chk("rst_dct_count", 32'(dct_count), 32'd0);
    chk("rst_dct_buffer", 32'(dct_buffer), 32'd0);
    chk("rst_has_ended", 32'(test_has_ended), 32'd0);
    chk("rst_atom_ready", 32'(atom_ready), 32'd1);

    // Full frame, sink always ready
    dct_ready = 1'b1;
    for (int i = 0; i < 15; i++) src_q.push_back(2'(i % 4));
    wait_src_empty(st);
    chk("full_no_stall", 32'(st), 32'd0);
    chk("full_latency_valid", 32'(dct_valid), 32'd1);
    chk("full_latency_count", 32'(dct_count), 32'd15);
    wait_frames(1);

    // Flush of a partial frame, then an empty flush
    src_q.push_back(2'd3); src_q.push_back(2'd3); src_q.push_back(2'd1);
    wait_src_empty(st);
    pulse_flush();
    wait_frames(2);
    cycles(2);
    pulse_flush();
    cycles(5);
    chk("empty_flush_valid", 32'(dct_valid), 32'd0);
    chk("empty_flush_frames", 32'(d_log.size()), 32'd2);

    // Backpressure: 32 atoms against a stalled sink
    dct_ready = 1'b0;
    for (int i = 0; i < 32; i++) src_q.push_back(2'(i % 4));
    cycles(40);
    chk("bp_valid", 32'(dct_valid), 32'd1);
    chk("bp_count", 32'(dct_count), 32'd15);
    chk("bp_buffer", 32'(dct_buffer), 32'h24E4E4E4);
    chk("bp_atom_ready", 32'(atom_ready), 32'd0);
    chk("bp_stalled_atoms", 32'(src_q.size()), 32'd2);
    dct_ready = 1'b1;
    wait_frames(4);
    chk("bp_back_to_back", 32'(d_log[3].cyc - d_log[2].cyc), 32'd1);
    wait_src_empty(st);
    pulse_flush();
    wait_frames(5);

    // Sixteen atoms: full frame then a one-atom remainder
    for (int i = 0; i < 15; i++) src_q.push_back(2'd1);
    src_q.push_back(2'd2);
    wait_src_empty(st);
    pulse_flush();
    wait_frames(7);

    // Flush move while atoms keep arriving
    src_q.push_back(2'd1); src_q.push_back(2'd2); src_q.push_back(2'd3);
    src_q.push_back(2'd0); src_q.push_back(2'd0); src_q.push_back(2'd2);
    cycles(3);
    pulse_flush();
    wait_src_empty(st);
    pulse_flush();
    wait_frames(9);

    // Reset with a held frame and a partial accumulator
    dct_ready = 1'b0;
    for (int i = 0; i < 22; i++) src_q.push_back(2'(i % 4));
    cycles(30);
    chk("mid_valid_before", 32'(dct_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_valid", 32'(dct_valid), 32'd0);
    chk("mid_count", 32'(dct_count), 32'd0);
    chk("mid_has_ended", 32'(test_has_ended), 32'd0);
    pulse_flush();
    cycles(5);
    chk("mid_flush_valid", 32'(dct_valid), 32'd0);

    // End of test drain
    src_q.push_back(2'd3); src_q.push_back(2'd2); src_q.push_back(2'd1);
    src_q.push_back(2'd0); src_q.push_back(2'd3);
    wait_src_empty(st);
    test_ending = 1'b1;
    cycles(4);
    chk("end_valid", 32'(dct_valid), 32'd1);
    chk("end_count", 32'(dct_count), 32'd5);
    chk("end_buffer", 32'(dct_buffer), 32'h0000031B);
    chk("end_atom_ready", 32'(atom_ready), 32'd0);
    chk("end_not_yet", 32'(test_has_ended), 32'd0);
    dct_ready = 1'b1;
    @(negedge clk);
    chk("end_valid_dropped", 32'(dct_valid), 32'd0);
    chk("end_has_ended", 32'(test_has_ended), 32'd1);
    cycles(5);
    chk("end_sticky", 32'(test_has_ended), 32'd1);

    // Literal frame list, for both the DUT and the model
    chk("frame_total", 32'(d_log.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < d_log.size()) begin
        chk($sformatf("dut_frame%0d_buf", i), 32'(d_log[i].b), 32'(exp_buf[i]));
        chk($sformatf("dut_frame%0d_cnt", i), 32'(d_log[i].c), 32'(exp_cnt[i]));
      end
      if (i < m_log.size()) begin
        chk($sformatf("model_frame%0d_buf", i), 32'(m_log[i].b), 32'(exp_buf[i]));
        chk($sformatf("model_frame%0d_cnt", i), 32'(m_log[i].c), 32'(exp_cnt[i]));
      end
    end
    chk("model_frame_total", 32'(m_log.size()), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_fprint_cpu_oci_dct_packer.md
Name: nios_fprint_cpu_oci_dct_packer

Overview:
- Producer side of the OCI debug-compression-trace (DCT) frame interface. Its outputs are the `dct_buffer`/`dct_count` frame and the `test_has_ended` status consumed by the OCI test-bench/trace sink.
- Accepts 2-bit trace atoms from the CPU trace logic and packs them LSB-first into 30-bit frames with a valid-atom count.
- Emits frames over a valid/ready handshake and handles explicit flush and end-of-test drain.
- Sits between the Nios II CPU trace-atom source and the OCI trace sink, in the processor1 OCI hierarchy.

Parameters:
- ATOM_W, 2, bits per trace atom.
- SLOTS, 15, atoms per full frame.
- BUF_W, 30, frame width; must equal ATOM_W*SLOTS.
- CNT_W, 4, count width; must satisfy 2^CNT_W > SLOTS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- atom_valid  in  1  atom offered this cycle.
- atom_data  in  ATOM_W  atom value.
- atom_ready  out  1  packer accepts atom this cycle.
- flush  in  1  single-cycle request to emit the partial frame.
- test_ending  in  1  level; begin end-of-test drain.
- dct_buffer  out  BUF_W  packed frame; atom k at bits [2k+1:2k].
- dct_count  out  CNT_W  number of valid atoms in dct_buffer, 1..15.
- dct_valid  out  1  frame presented.
- dct_ready  in  1  sink accepts frame.
- test_has_ended  out  1  drain complete; sticky.

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous, active-high.
- Reset values: all outputs 0, except atom_ready. atom_ready=1 in the cycle after reset deasserts. Internal accumulator, count, flush_pending and ending flag are cleared.
- Storage: accumulator `acc` (BUF_W bits) plus count `acc_cnt`, and a separate output register holding dct_buffer/dct_count/dct_valid (double buffered).
- Atom accept:
  - A transfer occurs when atom_valid && atom_ready.
  - atom_ready = (acc_cnt < SLOTS) && !ending. It is combinational from registered state only.
  - The accepted atom is written at slot acc_cnt, and acc_cnt increments.
- Frame move (acc -> output register) condition:
  - acc_cnt==SLOTS, or (flush_pending || ending) with acc_cnt>0;
  - AND the output register is free (!dct_valid, or dct_ready this cycle).
- On a move:
  - acc and acc_cnt clear and flush_pending clears.
  - An atom accepted in the same cycle lands in slot 0 of the fresh acc (acc_cnt=1).
  - Unused upper slots of the moved frame are 0.
- Latency: 15th atom accepted in cycle N with the output register free gives dct_valid=1 in cycle N+1, with dct_count=15.
- Output handshake:
  - dct_buffer and dct_count stay stable while dct_valid && !dct_ready.
  - dct_valid drops the cycle after acceptance unless a new move happens in that same cycle (back-to-back frames are allowed).
- Flush:
  - A flush pulse sets flush_pending.
  - Atoms accepted before the move occurs are included in the flushed frame.
  - If flush arrives with acc_cnt==0 and none pending, it is cleared with no frame. Empty frames are never emitted.
- End of test:
  - test_ending registers a sticky `ending` flag. An atom presented in the cycle test_ending first rises is still accepted.
  - Once ending is set, atom_ready=0, and the partial frame is moved as for flush.
  - test_has_ended asserts the cycle after both acc_cnt==0 and the output register is empty (last frame accepted). It stays 1 until reset.
- Full with backpressure: acc fills to 15, atom_ready=0 and no atom is lost; the move occurs on the first dct_ready.
- Simultaneous flush and full: a single move occurs and flush_pending clears.
- Reset mid-operation: all partial and pending frames are discarded, with no output in the following cycle.

Test Plan:
- Full frame: 15 back-to-back atoms with values 0,1,2,3 repeating and dct_ready=1 -> one cycle after the 15th atom: dct_valid=1, dct_count=15, dct_buffer=0x24E4E4E4; atom_ready stays 1 throughout.
- Flush partial: atoms 3,3,1 then flush -> frame with dct_count=3, dct_buffer=0x0000001F. A second flush with no atoms -> no dct_valid.
- Backpressure: dct_ready=0, 32 atoms offered -> first frame held stable; second acc fills to 15; atom_ready=0 with atoms 31 and 32 stalled. Raising dct_ready -> both frames delivered in consecutive cycles, then the remaining 2 atoms are accepted.
- End of test: 5 atoms, then test_ending=1 -> frame with dct_count=5 emitted, atom_ready=0, test_has_ended=1 one cycle after dct_ready handshake and sticky.
- Same-cycle move and accept: 15 atoms plus a 16th in the move cycle -> first frame count=15; acc restarts with count 1 holding atom 16.
- Reset mid-operation: assert reset with 7 atoms in acc and dct_valid=1 -> next cycle dct_valid=0, dct_count=0, test_has_ended=0; following flush emits nothing.
